cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Parametrised MIPS32 coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, plus an optional EBase.
- Provides a prescaled timer with compare interrupt, a configurable number of hardware interrupt lines, precise exception entry and eret.
- Sits beside the integer pipeline. The MEM stage drives mfc0/mtc0 and exception/eret commit. The fetch stage consumes the exception vector and EPC.

Parameters:
- ADDR_W, 8: CP0 address width; address = {rd[4:0], sel[2:0]}.
- HW_INT_NUM, 6: number of hardware interrupt inputs (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]. Unused IP bits read 0.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks (1..16).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- read_addr, input, ADDR_W: mfc0 register address.
- data_out, output, 32: mfc0 read data. Combinational from current state; no same-cycle write bypass.
- write_en, input, 1: mtc0 commit.
- write_addr, input, ADDR_W: mtc0 register address.
- write_data, input, 32: mtc0 data.
- interrupt, input, HW_INT_NUM: level hardware interrupts. Sampled every cycle.
- exc_valid, input, 1: exception commit.
- exc_code, input, 5: ExcCode value.
- exc_pc, input, 32: PC of the faulting instruction.
- exc_bd, input, 1: the faulting instruction is in a delay slot.
- exc_badvaddr, input, 32: faulting address.
- eret, input, 1: eret commit.
- int_pending, output, 1: interrupt request to the pipeline.
- epc_out, output, 32: current EPC (eret target).
- exc_vector, output, 32: exception handler address.
- status_out, output, 32: current Status.
- cause_out, output, 32: current Cause.

Behaviour:
- Addresses: BadVAddr 8/0, Count 9/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, EBase 15/1. Any other address reads 0 and ignores writes.
- Reset: Count=0, Compare=0, BadVAddr=0, EPC=0, Status=0x0040_0000 (BEV=1), Cause=0, divider=0, int_pending=0.
- Status writable bits: IM[15:8], EXL[1], IE[0]. All other bits are read-only, BEV=1.
- Cause: IP[1:0] is software-writable. IP[7:2] is loaded every cycle from interrupt[] (registered, 1-cycle latency). IP[7] is additionally ORed with TI. BD=bit31, TI=bit30, ExcCode=[6:2]. All other bits read 0.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments (wrapping 0xFFFFFFFF->0) when the divider wraps.
  - TI is set in the cycle after Count==Compare; it stays set until software writes Compare.
  - Writing Count loads write_data and resets the divider; the write wins over the increment.
  - Writing Compare clears TI in the same cycle; the clear wins over a simultaneous match.
- int_pending = IE & ~EXL & |(IP & IM), registered (1-cycle latency from the Cause/Status update).
- Exception entry (exc_valid=1):
  - If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and BD <= exc_bd.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1 and ExcCode <= exc_code.
  - BadVAddr <= exc_badvaddr only for ExcCode 4 (AdEL) or 5 (AdES).
- eret: EXL <= 0.
- Priority within one cycle: exc_valid > eret > mtc0 write, applied to the same field. Timer and interrupt sampling always proceed.
- exc_vector = 0xBFC0_0380 while BEV=1. The EBase path applies only when CP0_EBASE_EN is defined.
- Reset asserted mid-operation overrides everything in that cycle.

Optional Feature:
- Macro: CP0_EBASE_EN.
- Defined:
  - Adds EBase (15/1): reset 0x8000_0000; bits [29:12] writable, bit31=1, bits [11:0]=0.
  - Makes Status.BEV writable.
  - exc_vector = BEV ? 0xBFC0_0380 : EBase+0x180.
- Undefined: 15/1 reads 0, BEV is fixed at 1, and exc_vector is constant.

Decomposition:
- Package cp0_pkg holds:
  - register address constants;
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - Status/Cause bit-position constants;
  - reset values.
- Sub-module cp0_timer holds the divider, Count, Compare, match and TI. Its inputs are the Count/Compare write strobes and data; its outputs are Count, Compare and TI.

Test Plan:
- Reset, then read 12/0 -> 0x0040_0000; read 9/0 -> 0; int_pending=0.
- COUNT_DIV=2: after 10 clocks, Count=5. mtc0 Compare=8 -> TI=1 once Count reaches 8, and Cause bit30 and IP7 read 1. Write Compare=0 -> TI=0 the next cycle.
- Status=0x0000_0401 with interrupt[0] raised -> Cause.IP2=1 after 1 cycle, int_pending=1 one cycle later. Set EXL via an exception -> int_pending drops.
- exc_valid with code 4, pc=0xBFC0_0100, bd=1, badvaddr=0x1234_5671 -> EPC=0xBFC0_00FC, BD=1, ExcCode=4, BadVAddr=0x1234_5671, EXL=1. A second exception with pc=0x100 -> EPC unchanged. eret -> EXL=0.
- Same cycle: exc_valid, eret and mtc0 Status=0 -> EXL=1, IM/IE=0. Same cycle: Count write and increment -> Count=write_data.
- With CP0_EBASE_EN: write EBase=0x8000_1000 and clear BEV -> exc_vector=0x8000_1180. Without the macro: exc_vector=0xBFC0_0380 and 15/1 reads 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, exception codes, bit positions,
// reset values and a Status word packer.
package cp0_pkg;

    // Register addresses, encoded as {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_ADDR_BADVADDR = 8'h40;   // 8/0
    localparam logic [7:0] CP0_ADDR_COUNT    = 8'h48;   // 9/0
    localparam logic [7:0] CP0_ADDR_COMPARE  = 8'h58;   // 11/0
    localparam logic [7:0] CP0_ADDR_STATUS   = 8'h60;   // 12/0
    localparam logic [7:0] CP0_ADDR_CAUSE    = 8'h68;   // 13/0
    localparam logic [7:0] CP0_ADDR_EPC      = 8'h70;   // 14/0
    localparam logic [7:0] CP0_ADDR_EBASE    = 8'h79;   // 15/1

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_BEV    = 22;

    // Cause bit positions
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    // Reset values and vectors
    localparam logic [31:0] STATUS_RESET      = 32'h0040_0000;
    localparam logic [31:0] EBASE_RESET       = 32'h8000_0000;
    localparam logic [31:0] EXC_VECTOR_BOOT   = 32'hBFC0_0380;
    localparam logic [31:0] EXC_VECTOR_OFFSET = 32'h0000_0180;

    // Assemble the architectural Status word from its implemented fields
    function automatic logic [31:0] status_word(input logic bev, input logic [7:0] im,
                                                input logic exl, input logic ie);
        logic [31:0] w;
        w = 32'd0;
        w[STATUS_BEV] = bev;
        w[STATUS_IM_LO +: 8] = im;
        w[STATUS_EXL] = exl;
        w[STATUS_IE] = ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaler, Count, Compare and the sticky timer interrupt TI.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_ti;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div == DIV_W'(COUNT_DIV - 1));

    // Prescaler and Count; a software write reloads Count and restarts the prescaler
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div   <= '0;
            r_count <= 32'd0;
        end else if (i_count_we) begin
            r_div   <= '0;
            r_count <= i_write_data;
        end else if (w_div_wrap) begin
            r_div   <= '0;
            r_count <= r_count + 32'd1;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Compare register and sticky TI; writing Compare acknowledges the interrupt
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else if (i_compare_we) begin
            r_compare <= i_write_data;
            r_ti      <= 1'b0;
        end else if (r_count == r_compare) begin
            r_ti      <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// precise exception entry, eret and interrupt request generation.
// Optional macro CP0_EBASE_EN adds EBase (15/1) and a writable Status.BEV.
module cp0_regfile import cp0_pkg::*; #(
    parameter int ADDR_W     = 8,
    parameter int HW_INT_NUM = 6,
    parameter int COUNT_DIV  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_read_addr,
    output logic [31:0]           o_data_out,
    input  logic                  i_write_en,
    input  logic [ADDR_W-1:0]     i_write_addr,
    input  logic [31:0]           i_write_data,
    input  logic [HW_INT_NUM-1:0] i_interrupt,
    input  logic                  i_exc_valid,
    input  logic [4:0]            i_exc_code,
    input  logic [31:0]           i_exc_pc,
    input  logic                  i_exc_bd,
    input  logic [31:0]           i_exc_badvaddr,
    input  logic                  i_eret,
    output logic                  o_int_pending,
    output logic [31:0]           o_epc_out,
    output logic [31:0]           o_exc_vector,
    output logic [31:0]           o_status_out,
    output logic [31:0]           o_cause_out
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;
    logic        r_int_pending;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic        w_bev;
    logic [31:0] w_ebase;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_read_data;

    logic w_we_count, w_we_compare, w_we_status, w_we_cause, w_we_epc;

    assign w_we_count   = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_COUNT));
    assign w_we_compare = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_COMPARE));
    assign w_we_status  = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_STATUS));
    assign w_we_cause   = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_CAUSE));
    assign w_we_epc     = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_EPC));

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_count_we   (w_we_count),
        .i_compare_we (w_we_compare),
        .i_write_data (i_write_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Hardware interrupt lines are registered every cycle; unused lines read 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ip_hw <= 6'd0;
        end else begin
            r_ip_hw <= 6'(i_interrupt);
        end
    end

    // Status/Cause/EPC/BadVAddr update; exception beats eret beats mtc0 on shared fields
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_badvaddr <= 32'd0;
            r_epc      <= 32'd0;
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'd0;
            r_ip_sw    <= 2'd0;
        end else begin
            if (i_exc_valid) begin
                r_exl <= 1'b1;
            end else if (i_eret) begin
                r_exl <= 1'b0;
            end else if (w_we_status) begin
                r_exl <= i_write_data[STATUS_EXL];
            end
            if (w_we_status) begin
                r_im <= i_write_data[STATUS_IM_LO +: 8];
                r_ie <= i_write_data[STATUS_IE];
            end
            if (w_we_cause) begin
                r_ip_sw <= i_write_data[CAUSE_IP_LO +: 2];
            end
            if (i_exc_valid) begin
                // A nested exception keeps the original return point
                if (!r_exl) begin
                    r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
                    r_bd  <= i_exc_bd;
                end
                r_exccode <= i_exc_code;
                if ((i_exc_code == EXC_ADEL) || (i_exc_code == EXC_ADES)) begin
                    r_badvaddr <= i_exc_badvaddr;
                end
            end else if (w_we_epc) begin
                r_epc <= i_write_data;
            end
        end
    end

`ifdef CP0_EBASE_EN
    logic [17:0] r_ebase_hi;
    logic        r_bev;
    logic        w_we_ebase;

    assign w_we_ebase = i_write_en && (i_write_addr == ADDR_W'(CP0_ADDR_EBASE));

    // EBase base field and software-controlled BEV
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ebase_hi <= EBASE_RESET[29:12];
            r_bev      <= 1'b1;
        end else begin
            if (w_we_ebase) begin
                r_ebase_hi <= i_write_data[29:12];
            end
            if (w_we_status) begin
                r_bev <= i_write_data[STATUS_BEV];
            end
        end
    end

    assign w_ebase      = {2'b10, r_ebase_hi, 12'd0};
    assign w_bev        = r_bev;
    assign o_exc_vector = w_bev ? EXC_VECTOR_BOOT : (w_ebase + EXC_VECTOR_OFFSET);
`else
    assign w_ebase      = 32'd0;
    assign w_bev        = 1'b1;
    assign o_exc_vector = EXC_VECTOR_BOOT;
`endif

    assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
    assign w_status = status_word(w_bev, r_im, r_exl, r_ie);
    assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'd0};

    // Interrupt request is registered off the current Status/Cause state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_int_pending <= 1'b0;
        end else begin
            r_int_pending <= r_ie & ~r_exl & (|(w_ip & r_im));
        end
    end

    // mfc0 read mux; unmapped addresses read zero
    always_comb begin
        w_read_data = 32'd0;
        case (i_read_addr)
            ADDR_W'(CP0_ADDR_BADVADDR): w_read_data = r_badvaddr;
            ADDR_W'(CP0_ADDR_COUNT):    w_read_data = w_count;
            ADDR_W'(CP0_ADDR_COMPARE):  w_read_data = w_compare;
            ADDR_W'(CP0_ADDR_STATUS):   w_read_data = w_status;
            ADDR_W'(CP0_ADDR_CAUSE):    w_read_data = w_cause;
            ADDR_W'(CP0_ADDR_EPC):      w_read_data = r_epc;
            ADDR_W'(CP0_ADDR_EBASE):    w_read_data = w_ebase;
            default:                    w_read_data = 32'd0;
        endcase
    end

    assign o_data_out    = w_read_data;
    assign o_int_pending = r_int_pending;
    assign o_epc_out     = r_epc;
    assign o_status_out  = w_status;
    assign o_cause_out   = w_cause;

endmodule
